llander_thrust_arbiter: RTL and testbench

//  Owns the 8-bit THRUST value fed to the Lunar Lander core.

---
 rtl/llander_thrust_pkg.sv | 22 ++
 rtl/llander_tick_gen.sv | 26 ++
 rtl/llander_thrust_arbiter.sv | 115 +++++++++++
 tb/tb_llander_thrust_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/llander_thrust_pkg.sv
// rtl/llander_thrust_pkg.sv - shared state, mode and mapping definitions for the thrust arbiter
package llander_thrust_pkg;

    typedef enum logic [1:0] {
        S_DPAD = 2'd0,
        S_ANA  = 2'd1,
        S_HAND = 2'd2
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_ANALOG = 2'd1;
    localparam logic [1:0] MODE_DPAD   = 2'd2;

    // Stick Y (-128 = full up) to thrust: 127 - y spans 0..255, then clamp.
    function automatic logic [7:0] analog_to_thrust(input logic signed [7:0] s8,
                                                    input logic [7:0]        max);
        logic signed [8:0] t9;
        t9 = 9'sd127 - $signed({s8[7], s8});
        return (t9[7:0] > max) ? max : t9[7:0];
    endfunction

endpackage

// File: rtl/llander_tick_gen.sv
// rtl/llander_tick_gen.sv - ramp-tick prescaler with pause hold
module llander_tick_gen #(
    parameter int TICK_DIV = 196850
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic pause,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!pause) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tick = !pause && (count == LAST);

endmodule

// File: rtl/llander_thrust_arbiter.sv
// rtl/llander_thrust_arbiter.sv - bumpless analog/D-pad thrust arbiter (option: THRUST_SLEW_EN)
module llander_thrust_arbiter
    import llander_thrust_pkg::*;
#(
    parameter int TICK_DIV   = 196850,
    parameter int MAX_THRUST = 254,
    parameter int DEADZONE   = 8,
    parameter int SLEW_STEP  = 4
) (
    input  logic              clk_50,
    input  logic              RESET_L,
    input  logic [1:0]        mode,
    input  logic signed [7:0] analog_y,
    input  logic              dpad_up,
    input  logic              dpad_dn,
    input  logic              pause,
    output logic [7:0]        thrust,
    output logic              src_dpad,
    output logic              tick
);

    localparam logic [7:0] MAX_T = 8'(MAX_THRUST);
    localparam logic [7:0] DZ    = 8'(DEADZONE);

    state_t     state, state_next;
    logic [7:0] acc, acc_next, thrust_next;
    logic [7:0] target, abs_y, ana_next;
    logic       auto_mode, ana_active, dpad_any;

    llander_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_50 (clk_50),
        .rst_n  (RESET_L),
        .pause  (pause),
        .tick   (tick)
    );

    assign auto_mode  = (mode == MODE_AUTO) || (mode == 2'd3);
    assign dpad_any   = dpad_up || dpad_dn;
    // Unsigned magnitude so that -128 reads as 128.
    assign abs_y      = analog_y[7] ? (~analog_y + 8'd1) : analog_y;
    assign ana_active = abs_y > DZ;
    assign target     = analog_to_thrust(analog_y, MAX_T);

`ifdef THRUST_SLEW_EN
    localparam logic [7:0] SLEW = 8'(SLEW_STEP);
    logic [7:0] diff, step;

    always_comb begin
        diff     = (target >= thrust) ? (target - thrust) : (thrust - target);
        step     = (diff < SLEW) ? diff : SLEW;
        ana_next = thrust;
        if (tick) begin
            ana_next = (target >= thrust) ? (thrust + step) : (thrust - step);
        end
    end
`else
    assign ana_next = target;
`endif

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            state  <= S_DPAD;
            acc    <= 8'd0;
            thrust <= 8'd0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            thrust <= thrust_next;
        end
    end

    // Pause freezes acc/thrust; only mode-forced source changes still happen.
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        thrust_next = thrust;
        case (state)
            S_DPAD: begin
                if (tick) begin
                    if (dpad_up && !dpad_dn && acc < MAX_T) begin
                        acc_next = acc + 8'd1;
                    end else if (dpad_dn && !dpad_up && acc != 8'd0) begin
                        acc_next = acc - 8'd1;
                    end
                end
                thrust_next = acc_next;
                if (mode == MODE_ANALOG) begin
                    state_next = S_ANA;
                end else if (!pause && auto_mode && ana_active && !dpad_any) begin
                    state_next = S_ANA;
                end
            end
            S_ANA: begin
                if (!pause) begin
                    thrust_next = ana_next;
                end
                if (mode == MODE_DPAD) begin
                    state_next = S_HAND;
                end else if (!pause && auto_mode && dpad_any) begin
                    state_next = S_HAND;
                end
            end
            S_HAND: begin
                if (!pause) begin
                    acc_next   = thrust;
                    state_next = S_DPAD;
                end
            end
            default: state_next = S_DPAD;
        endcase
    end

    assign src_dpad = (state != S_ANA);

endmodule

// File: tb/tb_llander_thrust_arbiter.sv
// tb/tb_llander_thrust_arbiter.sv - directed scoreboard bench for llander_thrust_arbiter
module tb_llander_thrust_arbiter;
    import llander_thrust_pkg::*;

    localparam int TD = 4;

    logic              clk_50 = 1'b0;
    logic              RESET_L = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic signed [7:0] analog_y = 8'sd0;
    logic              dpad_up = 1'b0;
    logic              dpad_dn = 1'b0;
    logic              pause = 1'b0;
    logic [7:0]        thrust;
    logic              src_dpad;
    logic              tick;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk_50 = ~clk_50;

    llander_thrust_arbiter #(.TICK_DIV(TD)) dut (
        .clk_50   (clk_50),
        .RESET_L  (RESET_L),
        .mode     (mode),
        .analog_y (analog_y),
        .dpad_up  (dpad_up),
        .dpad_dn  (dpad_dn),
        .pause    (pause),
        .thrust   (thrust),
        .src_dpad (src_dpad),
        .tick     (tick)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (tick !== 1'b1 && n < 4 * TD) begin
            step();
            n++;
        end
        n_tests++;
        assert (tick === 1'b1) else begin
            n_fail++;
            $error("FAIL %s_tick_timeout observed=%0d expected=1", tag, tick);
        end
    endtask

    initial begin
        // Reset state
        step(2);
        expect_val("rst_thrust", 0);      check(thrust);
        expect_val("rst_src_dpad", 1);    check(src_dpad);
        expect_val("rst_tick", 0);        check(tick);
        expect_val("rst_acc", 0);         check(dut.acc);
        expect_val("rst_count", 0);       check(dut.u_tick.count);
        expect_val("rst_state", S_DPAD);  check(dut.state);

        // 1. Climb and hold, with 5. pause embedded at thrust 100
        RESET_L = 1'b1;
        mode    = MODE_DPAD;
        dpad_up = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            wait_tick("climb");
            step();
            expect_val("climb_thrust", (i > 254) ? 254 : i);
            check(thrust);
            if (i == 1) begin
                expect_val("tick_one_cycle", 0);
                check(tick);
            end
            if (i == 100) begin
                pause = 1'b1;
                for (int c = 0; c < 40; c++) begin
                    expect_val("pause_thrust", 100);
                    expect_val("pause_count", 0);
                    expect_val("pause_tick", 0);
                    expect_val("pause_state", S_DPAD);
                    step();
                    check(thrust);
                    check(dut.u_tick.count);
                    check(tick);
                    check(dut.state);
                end
                pause = 1'b0;
            end
        end

`ifndef THRUST_SLEW_EN
        // 2. Analog mapping, forced analog
        dpad_up  = 1'b0;
        mode     = MODE_ANALOG;
        analog_y = -8'sd128;
        expect_val("ana_src_dpad", 0);
        step();
        check(src_dpad);
        expect_val("ana_m128", 254);
        step();
        check(thrust);
        analog_y = 8'sd0;
        expect_val("ana_zero", 127);
        step();
        check(thrust);
        analog_y = 8'sd127;
        expect_val("ana_p127", 0);
        step();
        check(thrust);

        // 3. Handoff in auto mode
        mode     = MODE_AUTO;
        analog_y = -8'sd60;
        expect_val("hand_ana_thrust", 187);
        step();
        check(thrust);
        dpad_dn = 1'b1;
        expect_val("hand_state", S_HAND);
        expect_val("hand_src_dpad", 1);
        expect_val("hand_thrust", 187);
        step();
        check(dut.state);
        check(src_dpad);
        check(thrust);
        expect_val("hand_acc", 187);
        expect_val("hand_to_dpad", S_DPAD);
        step();
        check(dut.acc);
        check(dut.state);
        wait_tick("hand");
        expect_val("hand_first_tick", 186);
        step();
        check(thrust);

        // 4. Deadzone
        mode = MODE_DPAD;
        for (int k = 0; k < 146; k++) begin
            wait_tick("ramp_dn");
            step();
        end
        expect_val("dz_acc40", 40);
        check(thrust);
        dpad_dn  = 1'b0;
        mode     = MODE_AUTO;
        analog_y = 8'sd5;
        expect_val("dz5_src", 1);
        expect_val("dz5_thrust", 40);
        step(6);
        check(src_dpad);
        check(thrust);
        analog_y = 8'sd8;
        expect_val("dz8_src", 1);
        expect_val("dz8_thrust", 40);
        step(6);
        check(src_dpad);
        check(thrust);
        analog_y = 8'sd9;
        expect_val("dz9_state", S_ANA);
        step();
        check(dut.state);
        expect_val("dz9_thrust", 118);
        step();
        check(thrust);
        dpad_up = 1'b1;
        expect_val("dz_up_hand", S_HAND);
        step();
        check(dut.state);
        expect_val("dz_up_acc", 118);
        step();
        check(dut.acc);
        expect_val("dz_up_stays_dpad", S_DPAD);
        expect_val("dz_up_src", 1);
        step(2 * TD);
        check(dut.state);
        check(src_dpad);
        mode = MODE_ANALOG;
        expect_val("forced_ana_src", 0);
        step();
        check(src_dpad);
`else
        // 6. Slew toward target on ticks only
        dpad_up  = 1'b0;
        mode     = MODE_ANALOG;
        analog_y = 8'sd0;
        step();
        for (int k = 0; k < 32; k++) begin
            wait_tick("slew_settle");
            step();
        end
        expect_val("slew_settle_127", 127);
        check(thrust);
        analog_y = -8'sd128;
        for (int i = 1; i <= 32; i++) begin
            wait_tick("slew");
            step();
            expect_val("slew_thrust", (127 + 4 * i > 254) ? 254 : 127 + 4 * i);
            check(thrust);
            if (i == 1) begin
                expect_val("slew_hold", 131);
                step();
                check(thrust);
            end
        end
`endif

        // Async reset mid-ramp, then first tick TICK_DIV cycles after release
        mode     = MODE_DPAD;
        dpad_dn  = 1'b0;
        dpad_up  = 1'b1;
        analog_y = 8'sd0;
        step(3);
        wait_tick("pre_reset");
        step();
        #2 RESET_L = 1'b0;
        #1;
        expect_val("async_thrust", 0);
        expect_val("async_src", 1);
        expect_val("async_count", 0);
        expect_val("async_acc", 0);
        check(thrust);
        check(src_dpad);
        check(dut.u_tick.count);
        check(dut.acc);
        step();
        RESET_L = 1'b1;
        for (int k = 1; k <= TD; k++) begin
            expect_val("post_rst_tick", (k == TD - 1) ? 1 : 0);
            expect_val("post_rst_thrust", (k == TD) ? 1 : 0);
            step();
            check(tick);
            check(thrust);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
